// File: rtl/cordic_vec_arbiter.sv
// -----------------------------------------------------------------------------
// cordic_vec_arbiter
//   Shares one iterative CORDIC vectoring engine among NREQ requesters.
//   Round-robin grant, one job outstanding at a time, result returned tagged
//   with the requester index. The engine is only started from the START state,
//   so it never sees a start pulse while a job is in flight.
//
//   Optional feature macro: CORDIC_TMO_EN
//     defined   - WAIT runs a watchdog; after TMO_CYC cycles without eng_done the
//                 job completes with rsp_mag=0, rsp_phase=0, rsp_err=1.
//     undefined - WAIT holds until eng_done; rsp_err is constant 0.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   req_valid[NREQ]       per-requester job request
//   req_x/req_y           signed s3.8 operands, slot i at [12i+11:12i]
//   req_ready[NREQ]       one-hot accept, only ever high in GRANT
//   eng_start             one-cycle engine start pulse
//   eng_x/eng_y           operands of the granted job
//   eng_done              engine result-valid pulse
//   eng_mag/eng_phase     engine result, u4.8 magnitude and u1.20 phase
//   rsp_valid/rsp_ready   result handshake toward the consumer
//   rsp_id                requester index owning the result
//   rsp_mag/rsp_phase     result data, passed bit-exact
//   rsp_err               watchdog expiry flag
// -----------------------------------------------------------------------------
module cordic_vec_arbiter #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TMO_CYC = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*12-1:0] req_x,
    input  logic [NREQ*12-1:0] req_y,
    output logic [NREQ-1:0]    req_ready,
    output logic               eng_start,
    output logic [11:0]        eng_x,
    output logic [11:0]        eng_y,
    input  logic               eng_done,
    input  logic [11:0]        eng_mag,
    input  logic [20:0]        eng_phase,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [IDW-1:0]     rsp_id,
    output logic [11:0]        rsp_mag,
    output logic [20:0]        rsp_phase,
    output logic               rsp_err
);

    // Elaboration-time guard on the parameter set.
    if (NREQ < 2 || NREQ > 8 || (1 << IDW) < NREQ || TMO_CYC < 1) begin : g_param_check
        $error("cordic_vec_arbiter: illegal parameter set");
    end

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_GRANT = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    logic [2:0]     r_state;
    logic [IDW-1:0] r_ptr;
    logic [11:0]    r_eng_x;
    logic [11:0]    r_eng_y;
    logic [IDW-1:0] r_rsp_id;
    logic [11:0]    r_rsp_mag;
    logic [20:0]    r_rsp_phase;

    logic [NREQ-1:0] w_rot;
    logic            w_any;
    logic [IDW-1:0]  w_off;
    logic [IDW:0]    w_sum;
    logic [IDW-1:0]  w_win;
    logic [IDW-1:0]  w_ptr_nxt;
    logic [11:0]     w_sel_x;
    logic [11:0]     w_sel_y;

    // Rotate the request vector so bit 0 is the slot the pointer favours.
    assign w_rot = NREQ'({req_valid, req_valid} >> r_ptr);

    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // so no path leaves a value held and no latch is inferred.
        w_any = 1'b0;
        w_off = '0;
        // Scan from the far end back toward the pointer; the nearest hit is the
        // last one written and therefore wins.
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_any = 1'b1;
                w_off = IDW'(k);
            end
        end
    end

    // Winner index = (ptr + offset) mod NREQ.
    assign w_sum     = {1'b0, r_ptr} + {1'b0, w_off};
    assign w_win     = (w_sum >= (IDW+1)'(NREQ)) ? IDW'(w_sum - (IDW+1)'(NREQ)) : IDW'(w_sum);
    assign w_ptr_nxt = (w_win == IDW'(NREQ - 1)) ? '0 : w_win + 1'b1;

    always_comb begin
        w_sel_x = '0;
        w_sel_y = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win == IDW'(i)) begin
                w_sel_x = req_x[12*i +: 12];
                w_sel_y = req_y[12*i +: 12];
            end
        end
    end

    // Accept is combinational in GRANT so the requester sees it in the same
    // cycle the operands are captured.
    always_comb begin
        req_ready = '0;
        if (r_state == S_GRANT && w_any) begin
            req_ready[w_win] = 1'b1;
        end
    end

`ifdef CORDIC_TMO_EN
    localparam int TMO_W = $clog2(TMO_CYC + 1);
    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_rsp_err;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: every register, including the data latches, is reset so the
        // outputs are defined 0 straight out of reset and an abandoned job
        // leaves nothing behind.
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_eng_x     <= '0;
            r_eng_y     <= '0;
            r_rsp_id    <= '0;
            r_rsp_mag   <= '0;
            r_rsp_phase <= '0;
`ifdef CORDIC_TMO_EN
            r_tmo_cnt   <= '0;
            r_rsp_err   <= 1'b0;
`endif
        end else begin
            // NOTE: state updates use non-blocking assignments so every
            // register samples the pre-edge values of the others.
            case (r_state)
                S_IDLE: begin
                    if (|req_valid) r_state <= S_GRANT;
                end
                S_GRANT: begin
                    if (w_any) begin
                        r_eng_x  <= w_sel_x;
                        r_eng_y  <= w_sel_y;
                        r_rsp_id <= w_win;
                        r_ptr    <= w_ptr_nxt;
                        r_state  <= S_START;
                    end else begin
                        // Request withdrawn before it could be accepted.
                        r_state <= S_IDLE;
                    end
                end
                S_START: begin
`ifdef CORDIC_TMO_EN
                    r_tmo_cnt <= '0;
`endif
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // eng_done takes priority over a watchdog expiry in the same cycle.
                    if (eng_done) begin
                        r_rsp_mag   <= eng_mag;
                        r_rsp_phase <= eng_phase;
`ifdef CORDIC_TMO_EN
                        r_rsp_err   <= 1'b0;
`endif
                        r_state     <= S_RESP;
                    end
`ifdef CORDIC_TMO_EN
                    else if (r_tmo_cnt == TMO_W'(TMO_CYC - 1)) begin
                        r_rsp_mag   <= '0;
                        r_rsp_phase <= '0;
                        r_rsp_err   <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
`endif
                end
                S_RESP: begin
                    if (rsp_ready) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign eng_start = (r_state == S_START);
    assign eng_x     = r_eng_x;
    assign eng_y     = r_eng_y;
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_id    = r_rsp_id;
    assign rsp_mag   = r_rsp_mag;
    assign rsp_phase = r_rsp_phase;
`ifdef CORDIC_TMO_EN
    assign rsp_err   = r_rsp_err;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_cordic_vec_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cordic_vec_arbiter
//   Directed and randomized jobs against cordic_vec_arbiter. The bench keeps a
//   list of pending requests and a round-robin pointer, predicts each winner
//   from those, plays the engine itself, and compares every grant, operand
//   hand-off and response.
// -----------------------------------------------------------------------------
module tb_cordic_vec_arbiter;

    localparam int NREQ    = 4;
    localparam int IDW     = 2;
    localparam int TMO_CYC = 64;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*12-1:0] req_x;
    logic [NREQ*12-1:0] req_y;
    logic [NREQ-1:0]    req_ready;
    logic               eng_start;
    logic [11:0]        eng_x;
    logic [11:0]        eng_y;
    logic               eng_done;
    logic [11:0]        eng_mag;
    logic [20:0]        eng_phase;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic [11:0]        rsp_mag;
    logic [20:0]        rsp_phase;
    logic               rsp_err;

    int total = 0;
    int bad   = 0;

    // Reference state: who is waiting, with what operands, and where the
    // round-robin search starts.
    bit          pend[NREQ];
    logic [11:0] px[NREQ];
    logic [11:0] py[NREQ];
    int          m_ptr;

    always #5 clk = ~clk;

    cordic_vec_arbiter #(.NREQ(NREQ), .IDW(IDW), .TMO_CYC(TMO_CYC)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_x(req_x), .req_y(req_y), .req_ready(req_ready),
        .eng_start(eng_start), .eng_x(eng_x), .eng_y(eng_y),
        .eng_done(eng_done), .eng_mag(eng_mag), .eng_phase(eng_phase),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_mag(rsp_mag), .rsp_phase(rsp_phase), .rsp_err(rsp_err)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and land 2 time units past the edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]       = pend[i];
            req_x[12*i +: 12]  = px[i];
            req_y[12*i +: 12]  = py[i];
        end
    endtask

    task automatic add_req(input int i, input logic [11:0] x, input logic [11:0] y);
        pend[i] = 1'b1;
        px[i]   = x;
        py[i]   = y;
    endtask

    function automatic int pick();
        for (int k = 0; k < NREQ; k++) begin
            if (pend[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic bit any_pend();
        for (int i = 0; i < NREQ; i++) if (pend[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        eng_done  = 1'b0;
        rsp_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
        m_ptr = 0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    // One complete job from an IDLE sample point. lat = WAIT cycles before the
    // engine answers (negative: never answers). hold = cycles rsp_ready stays low.
    task automatic run_job(input int lat, input logic [11:0] mag, input logic [20:0] ph,
                           input int hold, input bit exp_err, output int win);
        int          exp_win;
        int          n;
        bit          got;
        logic [11:0] ex;
        logic [11:0] ey;
        logic [11:0] e_mag;
        logic [20:0] e_ph;

        exp_win = pick();
        drive_reqs();
        got = 1'b0;
        for (n = 0; n < 4 && !got; n++) begin
            step();
            if (req_ready != '0) got = 1'b1;
        end
        check("grant_seen", 32'(got), 32'd1);
        win = -1;
        if (!got) return;

        check("ready_onehot", 32'($onehot(req_ready)), 32'd1);
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) win = i;
        check("grant_id", win, exp_win);
        ex = px[exp_win];
        ey = py[exp_win];
        pend[exp_win] = 1'b0;
        m_ptr = (exp_win + 1) % NREQ;

        step();                 // START
        drive_reqs();           // accepted requester withdraws
        check("start_pulse", 32'(eng_start), 32'd1);
        check("eng_x", 32'(eng_x), 32'(ex));
        check("eng_y", 32'(eng_y), 32'(ey));
        check("ready_off_start", 32'(req_ready), 32'd0);

        if (lat >= 0) begin
            for (int j = 0; j <= lat; j++) begin
                step();
                if (j == 0) check("start_one_cycle", 32'(eng_start), 32'd0);
                check("no_rsp_in_wait", 32'(rsp_valid), 32'd0);
                if (j == lat) begin
                    eng_done  = 1'b1;
                    eng_mag   = mag;
                    eng_phase = ph;
                end
            end
            step();
            eng_done = 1'b0;
        end else begin
            for (n = 1; n <= 300; n++) begin
                step();
                if (rsp_valid) break;
            end
            check("tmo_latency", n, TMO_CYC + 1);
        end

        e_mag = exp_err ? 12'h000 : mag;
        e_ph  = exp_err ? 21'h0 : ph;
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        check("rsp_id", 32'(rsp_id), exp_win);
        check("rsp_mag", 32'(rsp_mag), 32'(e_mag));
        check("rsp_phase", 32'(rsp_phase), 32'(e_ph));
        check("rsp_err", 32'(rsp_err), 32'(exp_err));

        for (int h = 0; h < hold; h++) begin
            // A stray engine pulse in RESP must not disturb the held result.
            eng_done  = (h == 1);
            eng_mag   = ~mag;
            eng_phase = ~ph;
            step();
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_mag", 32'(rsp_mag), 32'(e_mag));
            check("hold_phase", 32'(rsp_phase), 32'(e_ph));
            check("hold_id", 32'(rsp_id), exp_win);
            check("hold_no_ready", 32'(req_ready), 32'd0);
            check("hold_no_start", 32'(eng_start), 32'd0);
        end
        eng_done  = 1'b0;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("rsp_drop", 32'(rsp_valid), 32'd0);
    endtask

    int w;
    int order[6] = '{0, 1, 2, 3, 0, 1};

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_x     = '0;
        req_y     = '0;
        eng_done  = 1'b0;
        eng_mag   = '0;
        eng_phase = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 1'b0;
            px[i]   = '0;
            py[i]   = '0;
        end
        m_ptr = 0;

        // Reset state
        #12;
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_start", 32'(eng_start), 32'd0);
        check("rst_eng_xy", {8'd0, eng_x, eng_y}, 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_fields", {rsp_id, rsp_mag, rsp_err}, 32'd0);
        check("rst_rsp_phase", 32'(rsp_phase), 32'd0);
        rst_n = 1'b1;
        step();

        // Single job on requester 0
        add_req(0, 12'h100, 12'h000);
        run_job(19, 12'h100, 21'h0, 0, 1'b0, w);
        check("single_id", w, 0);

        // All requesters keep requesting: strict rotation from slot 0
        do_reset();
        for (int j = 0; j < 6; j++) begin
            for (int i = 0; i < NREQ; i++)
                if (!pend[i]) add_req(i, 12'($urandom), 12'($urandom));
            run_job($urandom_range(0, 8), 12'($urandom), 21'($urandom), 0, 1'b0, w);
            check("rr_order", w, order[j]);
        end

        // Consumer stalls 10 cycles in RESP
        run_job(5, 12'($urandom), 21'($urandom), 10, 1'b0, w);
        while (any_pend()) run_job($urandom_range(0, 6), 12'($urandom), 21'($urandom), 0, 1'b0, w);

        // Request 2 pulsed for one cycle only, withdrawn before GRANT evaluates
        req_valid = 4'b0100;
        step();
        req_valid = '0;
        #1;
        check("pulse_no_ready", 32'(req_ready), 32'd0);
        step();
        check("pulse_no_start", 32'(eng_start), 32'd0);
        step();
        check("pulse_still_idle", {30'd0, eng_start, rsp_valid}, 32'd0);

        // Pointer must be unaffected by the withdrawn request
        add_req(1, 12'($urandom), 12'($urandom));
        add_req(3, 12'($urandom), 12'($urandom));
        while (any_pend()) run_job($urandom_range(0, 6), 12'($urandom), 21'($urandom), 1, 1'b0, w);

`ifdef CORDIC_TMO_EN
        // Engine never answers: watchdog completes the job with an error
        add_req(2, 12'($urandom), 12'($urandom));
        run_job(-1, 12'h0, 21'h0, 2, 1'b1, w);
        // Next job is served normally
        add_req(0, 12'($urandom), 12'($urandom));
        run_job(7, 12'hABC, 21'h12345, 0, 1'b0, w);
        // eng_done on the expiry cycle wins
        add_req(1, 12'($urandom), 12'($urandom));
        run_job(TMO_CYC - 1, 12'h5A5, 21'h1F0F0, 0, 1'b0, w);
`else
        // Without the watchdog WAIT holds well past TMO_CYC
        add_req(2, 12'($urandom), 12'($urandom));
        run_job(150, 12'h7E1, 21'h0ABCD, 0, 1'b0, w);
`endif

        // Randomized traffic
        for (int j = 0; j < 30; j++) begin
            for (int i = 0; i < NREQ; i++)
                if (!pend[i] && $urandom_range(0, 1) == 1) add_req(i, 12'($urandom), 12'($urandom));
            if (!any_pend()) add_req($urandom_range(0, NREQ - 1), 12'($urandom), 12'($urandom));
            run_job($urandom_range(0, 40), 12'($urandom), 21'($urandom), $urandom_range(0, 3), 1'b0, w);
        end
        while (any_pend()) run_job($urandom_range(0, 6), 12'($urandom), 21'($urandom), 0, 1'b0, w);

        // Reset in the middle of WAIT, then a late eng_done
        add_req(1, 12'h3C3, 12'h0F0);
        drive_reqs();
        step();                 // GRANT
        step();                 // START
        pend[1] = 1'b0;
        drive_reqs();
        step();                 // WAIT
        step();
        rst_n = 1'b0;
        #1;
        check("midrst_outputs", {rsp_valid, eng_start, req_ready, eng_x, eng_y}, 32'd0);
        check("midrst_rsp", {rsp_id, rsp_mag, rsp_err}, 32'd0);
        step();
        rst_n = 1'b1;
        m_ptr = 0;
        step();
        eng_done  = 1'b1;
        eng_mag   = 12'hFFF;
        eng_phase = 21'h1FFFFF;
        step();
        eng_done = 1'b0;
        step();
        check("stray_done_no_rsp", 32'(rsp_valid), 32'd0);
        check("stray_done_fields", {rsp_id, rsp_mag, rsp_err, eng_start}, 32'd0);
        check("stray_done_phase", 32'(rsp_phase), 32'd0);
        for (int i = 0; i < NREQ; i++) add_req(i, 12'($urandom), 12'($urandom));
        run_job(3, 12'h111, 21'h22222, 0, 1'b0, w);
        check("ptr_restart", w, 0);
        while (any_pend()) run_job($urandom_range(0, 4), 12'($urandom), 21'($urandom), 0, 1'b0, w);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
